// File: rtl/waveform_loop_fifo.sv
// Per-channel waveform store feeding the DAC playback controller.
// Load mode takes words from the PS stream. Loop-back mode writes every popped word back to
// the tail, so the stored waveform recirculates with no PS involvement.
// The head word is registered and shown first-word-fall-through. A word written at edge N
// becomes visible at the head after edge N+2.
// Optional build macro: WFIFO_ERR_FLAGS_EN adds the sticky underflow_err and overflow_err outputs.
module waveform_loop_fifo #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  mux_sel,
  input  logic                  loopback_valid,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   word_count
`ifdef WFIFO_ERR_FLAGS_EN
  ,
  output logic                  underflow_err,
  output logic                  overflow_err
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] last_wr_ptr_q;
  logic                  last_push_q;
  logic [ADDR_WIDTH:0]   count_q, count_d, old_cnt;
  logic                  mode_q;
  logic                  ready_q, ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  push, pop, write_en, head_visible;
  logic [DATA_WIDTH-1:0] push_data;

  assign s_axis_tready = ready_q & ~flush;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign word_count    = count_q;
  assign pop           = out_valid_q & m_axis_tready;
  assign write_en      = push & ~flush;

  // Push selection, pointer/occupancy update and next head word.
  always_comb begin
    push      = 1'b0;
    push_data = s_axis_tdata;
    if (mode_q) begin
      // Loop-back: the popped head is rewritten to the tail in the same cycle.
      push      = pop & loopback_valid;
      push_data = out_data_q;
    end else begin
      push = s_axis_tvalid & s_axis_tready;
    end

    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    old_cnt  = count_q - {{ADDR_WIDTH{1'b0}}, pop};
    count_d  = old_cnt + {{ADDR_WIDTH{1'b0}}, push};

    // Next head must predate this edge's write and must not be the word written last edge.
    head_visible = (old_cnt != '0) && !(last_push_q && (last_wr_ptr_q == rd_ptr_d));
    out_valid_d  = head_visible;
    out_data_d   = head_visible ? mem[rd_ptr_d] : '0;
    ready_d      = ~mux_sel & (count_d < FULL_CNT);

    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      ready_d     = ~mux_sel;
    end
  end

  // Control state and registered head word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      last_wr_ptr_q <= '0;
      last_push_q   <= 1'b0;
      count_q       <= '0;
      mode_q        <= 1'b0;
      ready_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      last_wr_ptr_q <= wr_ptr_q;
      last_push_q   <= write_en;
      count_q       <= count_d;
      mode_q        <= mux_sel;
      ready_q       <= ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

  // Waveform storage, no reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

`ifdef WFIFO_ERR_FLAGS_EN
  logic underflow_q, overflow_q;

  assign underflow_err = underflow_q;
  assign overflow_err  = overflow_q;

  // Sticky error flags, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (flush) begin
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      underflow_q <= underflow_q | (m_axis_tready & ~out_valid_q & mux_sel);
      overflow_q  <= overflow_q | (s_axis_tvalid & (count_q == FULL_CNT) & ~mux_sel);
    end
  end
`endif

endmodule

// File: tb/tb_waveform_loop_fifo.sv
// Bench for waveform_loop_fifo: constant vector table, hand sequences, random phase against
// a queue model in which each word carries the edge index at which it was written.
module tb_waveform_loop_fifo;
  localparam int DW    = 256;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          mux_sel = 1'b0;
  logic          loopback_valid = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   word_count;
`ifdef WFIFO_ERR_FLAGS_EN
  logic          underflow_err;
  logic          overflow_err;
`endif

  waveform_loop_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .mux_sel        (mux_sel),
    .loopback_valid (loopback_valid),
    .flush          (flush),
    .word_count     (word_count)
`ifdef WFIFO_ERR_FLAGS_EN
    ,
    .underflow_err  (underflow_err),
    .overflow_err   (overflow_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words in order, each with its write edge.
  typedef struct {
    logic [DW-1:0] d;
    int            w;
  } ent_t;
  ent_t q[$];
  int   edge_n = 0;
  bit   m_rdy  = 1'b0;
  bit   m_mode = 1'b0;
`ifdef WFIFO_ERR_FLAGS_EN
  bit   m_uf = 1'b0;
  bit   m_of = 1'b0;
`endif

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          ms;
    logic          tr;
    logic          lbv;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    int            ec;
    logic          er;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // A word is at the visible head once it was written at least two edges ago.
  function automatic bit model_vis();
    return (q.size() > 0) && (q[0].w + 2 <= edge_n);
  endfunction

  function automatic logic [DW-1:0] model_head();
    return model_vis() ? q[0].d : '0;
  endfunction

  task automatic check_model(input string name);
    check({name, " tvalid"}, DW'(m_axis_tvalid), DW'(model_vis()));
    check({name, " tdata"}, m_axis_tdata, model_head());
    check({name, " word_count"}, DW'(word_count), DW'(q.size()));
    check({name, " s_tready"}, DW'(s_axis_tready), DW'(m_rdy && !flush));
`ifdef WFIFO_ERR_FLAGS_EN
    check({name, " underflow_err"}, DW'(underflow_err), DW'(m_uf));
    check({name, " overflow_err"}, DW'(overflow_err), DW'(m_of));
`endif
  endtask

  // One clock: evaluate the model on current inputs, step through the edge, update, compare.
  task automatic cycle(input bit cmp, input string name);
    bit            v, pop, rdy, push;
    logic [DW-1:0] pd;
`ifdef WFIFO_ERR_FLAGS_EN
    bit            uf_set, of_set;
    uf_set = m_axis_tready && !model_vis() && mux_sel;
    of_set = s_axis_tvalid && (q.size() == DEPTH) && !mux_sel;
`endif
    v    = model_vis();
    pop  = v && m_axis_tready;
    rdy  = m_rdy && !flush;
    push = 1'b0;
    pd   = s_axis_tdata;
    if (m_mode) begin
      push = pop && loopback_valid;
      if (push) pd = q[0].d;
    end else begin
      push = s_axis_tvalid && rdy;
    end
    @(posedge clk);
    #1;
    edge_n++;
    if (flush) begin
      q.delete();
`ifdef WFIFO_ERR_FLAGS_EN
      m_uf = 1'b0;
      m_of = 1'b0;
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{d: pd, w: edge_n});
`ifdef WFIFO_ERR_FLAGS_EN
      m_uf = m_uf | uf_set;
      m_of = m_of | of_set;
`endif
    end
    m_rdy  = !mux_sel && (q.size() < DEPTH);
    m_mode = mux_sel;
    if (cmp) check_model(name);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdy  = 1'b0;
    m_mode = 1'b0;
`ifdef WFIFO_ERR_FLAGS_EN
    m_uf = 1'b0;
    m_of = 1'b0;
`endif
  endtask

  task automatic set_in(input logic sv, input logic ms, input logic tr, input logic lbv,
                        input logic fl);
    s_axis_tvalid  = sv;
    mux_sel        = ms;
    m_axis_tready  = tr;
    loopback_valid = lbv;
    flush          = fl;
  endtask

  logic [DW-1:0] first_new;

  initial begin
    // Vector table: 4-word load, switch to loop-back, 12 recirculating pops.
    vecs[0] = '{sv: 0, sd: 0, ms: 0, tr: 0, lbv: 0, fl: 0, ev: 0, ed: 0, ec: 0, er: 1};
    for (int i = 1; i <= 4; i++) begin
      vecs[i] = '{sv: 1, sd: DW'(i), ms: 0, tr: 0, lbv: 0, fl: 0,
                  ev: (i >= 3), ed: (i >= 3) ? DW'(1) : DW'(0), ec: i, er: 1};
    end
    vecs[5] = '{sv: 0, sd: 0, ms: 0, tr: 0, lbv: 0, fl: 0, ev: 1, ed: 1, ec: 4, er: 1};
    vecs[6] = '{sv: 0, sd: 0, ms: 1, tr: 0, lbv: 0, fl: 0, ev: 1, ed: 1, ec: 4, er: 0};
    for (int k = 0; k < 12; k++) begin
      vecs[7+k] = '{sv: 0, sd: 0, ms: 1, tr: 1, lbv: 1, fl: 0,
                    ev: 1, ed: DW'(((k + 1) % 4) + 1), ec: 4, er: 0};
    end

    // Reset state.
    #12;
    check("reset tvalid", DW'(m_axis_tvalid), '0);
    check("reset tdata", m_axis_tdata, '0);
    check("reset word_count", DW'(word_count), '0);
    check("reset s_tready", DW'(s_axis_tready), '0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      s_axis_tdata = vecs[i].sd;
      set_in(vecs[i].sv, vecs[i].ms, vecs[i].tr, vecs[i].lbv, vecs[i].fl);
      cycle(1'b0, "vec");
      check($sformatf("vec%0d tvalid", i), DW'(m_axis_tvalid), DW'(vecs[i].ev));
      check($sformatf("vec%0d tdata", i), m_axis_tdata, vecs[i].ed);
      check($sformatf("vec%0d word_count", i), DW'(word_count), DW'(vecs[i].ec));
      check($sformatf("vec%0d s_tready", i), DW'(s_axis_tready), DW'(vecs[i].er));
    end

    // Fill to full, then loop-back for 2048 pops across pointer wrap.
    set_in(0, 0, 0, 0, 1);
    cycle(1'b1, "fill flush");
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 1100 && q.size() < DEPTH; i++) begin
      s_axis_tdata = rand_word();
      cycle(1'b1, "fill");
    end
    check("fill reached full", DW'(word_count), DW'(DEPTH));
    cycle(1'b1, "push at full");
    set_in(0, 1, 0, 0, 0);
    cycle(1'b1, "to loop-back");
    set_in(0, 1, 1, 1, 0);
    for (int i = 0; i < 2048; i++) begin
      cycle(1'b1, "full loop");
      if (i % 256 == 0) begin
        check("full loop count", DW'(word_count), DW'(DEPTH));
        check("full loop tvalid", DW'(m_axis_tvalid), DW'(1));
        check("full loop s_tready", DW'(s_axis_tready), '0);
      end
    end

    // Drain 3 words in load mode, then pop-on-empty in both modes.
    set_in(0, 0, 0, 0, 1);
    cycle(1'b1, "drain flush");
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata = rand_word();
      cycle(1'b1, "drain load");
    end
    set_in(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, "drain pop");
    check("drained tvalid", DW'(m_axis_tvalid), '0);
    check("drained tdata", m_axis_tdata, '0);
    check("drained count", DW'(word_count), '0);
`ifdef WFIFO_ERR_FLAGS_EN
    check("underflow load mode", DW'(underflow_err), '0);
`endif
    set_in(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, "empty loop pop");
`ifdef WFIFO_ERR_FLAGS_EN
    check("underflow loop mode", DW'(underflow_err), DW'(1));
`endif

    // Flush during loop-back with 8 words, then reload fresh data.
    set_in(0, 0, 0, 0, 1);
    cycle(1'b1, "c flush0");
    set_in(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = rand_word();
      cycle(1'b1, "c load");
    end
    set_in(0, 1, 0, 0, 0);
    cycle(1'b1, "c mode");
    set_in(0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, "c loop");
    check("c count before flush", DW'(word_count), DW'(8));
    set_in(0, 1, 1, 1, 1);
    cycle(1'b1, "c flush");
    check("flush count", DW'(word_count), '0);
    check("flush tvalid", DW'(m_axis_tvalid), '0);
    set_in(0, 0, 0, 0, 0);
    cycle(1'b1, "c idle");
    first_new    = rand_word();
    s_axis_tdata = first_new;
    set_in(1, 0, 0, 0, 0);
    cycle(1'b1, "c reload0");
    s_axis_tdata = rand_word();
    cycle(1'b1, "c reload1");
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, "c settle");
    check("fresh head", m_axis_tdata, first_new);

    // Asynchronous reset between edges during loop-back.
    set_in(0, 1, 0, 0, 0);
    cycle(1'b1, "d mode");
    set_in(0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, "d loop");
    #2;
    rst = 1'b0;
    #1;
    check("async rst tvalid", DW'(m_axis_tvalid), '0);
    check("async rst tdata", m_axis_tdata, '0);
    check("async rst count", DW'(word_count), '0);
    check("async rst s_tready", DW'(s_axis_tready), '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cycle(1'b1, "d release");
    check("ready after release", DW'(s_axis_tready), DW'(1));

    // Random phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) mux_sel = ~mux_sel;
      s_axis_tvalid  = $urandom_range(0, 1) != 0;
      s_axis_tdata   = rand_word();
      m_axis_tready  = mux_sel ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
      loopback_valid = $urandom_range(0, 4) != 0;
      flush          = $urandom_range(0, 149) == 0;
      cycle(1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/waveform_loop_fifo.md
Name: waveform_loop_fifo

Overview:
- Per-channel waveform store that sits directly upstream of the DAC playback controller and drives its s_axis input.
- In load mode, PS writes the waveform as 256-bit DAC words through the PS AXI-stream port.
- In loop-back mode, every word consumed by the playback controller while loopback_valid is high is written back to the tail. The waveform therefore recirculates on every trigger with no PS involvement.

Parameters:
- DATA_WIDTH, 256, width of one DAC word (16 samples x 16 bit).
- ADDR_WIDTH, 10, log2 of depth; depth = 2**ADDR_WIDTH words (1024).

Ports:
- clk  input  1  250 MHz RFSoC DAC fabric clock.
- rst  input  1  asynchronous reset, active-low.
- s_axis_tdata  input  DATA_WIDTH  PS load data.
- s_axis_tvalid  input  1  PS load valid.
- s_axis_tready  output  1  PS load ready.
- m_axis_tdata  output  DATA_WIDTH  head word to playback controller.
- m_axis_tvalid  output  1  head word valid (FIFO non-empty).
- m_axis_tready  input  1  pop request from playback controller.
- mux_sel  input  1  0 = load from PS, 1 = loop-back.
- loopback_valid  input  1  high while popped words are to be rewritten.
- flush  input  1  synchronous clear of contents and pointers.
- word_count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.

Behaviour:
- Reset (rst=0, async): write and read pointers = 0, word_count = 0, m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0. Memory contents undefined.
- First-word-fall-through: m_axis_tdata always presents the head word, registered. The playback controller samples it before asserting tready.
- Write-to-visible latency into an empty FIFO: 2 cycles. Write at edge N; m_axis_tvalid and data valid after edge N+2.
- pop = m_axis_tvalid & m_axis_tready. When m_axis_tready=1 and the FIFO is empty, the request is ignored: no pointer move, and m_axis_tdata = 0 while m_axis_tvalid = 0.
- Load mode (mux_sel=0):
  - s_axis_tready = (word_count < depth) & !flush.
  - push = s_axis_tvalid & s_axis_tready, data from s_axis_tdata.
  - Popped words are discarded.
- Loop-back mode (mux_sel=1):
  - s_axis_tready = 0.
  - push = pop & loopback_valid, data = the popped head word, written to the tail in the same cycle.
  - Pop without loopback_valid drains the word.
- Simultaneous push and pop: word_count unchanged and both pointers advance. This is legal at full (loop-back at full is the normal steady state) and at count 1.
- Pointers wrap modulo depth. word_count uses ADDR_WIDTH+1 bits, so full is distinguishable from empty.
- Push attempted when full with no pop cannot occur in load mode (tready low). In loop-back mode it is impossible by construction.
- mux_sel change: takes effect on the next cycle's push/ready evaluation. No in-flight loop-back word is lost, because push and pop are same-cycle.
- flush=1: at next edge, pointers = 0, word_count = 0, m_axis_tvalid = 0, m_axis_tdata = 0. flush overrides a simultaneous push or pop.
- Reset asserted mid-playback: immediate clear as above. The controller is reset by the same rst.
- word_count is registered and updated at the same edge as the pointers.

Optional Feature:
- Macro WFIFO_ERR_FLAGS_EN.
- Defined: adds outputs underflow_err (1) and overflow_err (1), sticky, cleared only by rst or flush, reset 0.
  - underflow_err sets when m_axis_tready=1 while m_axis_tvalid=0 and mux_sel=1 (playback ran past the stored waveform).
  - overflow_err sets when s_axis_tvalid=1 while word_count==depth and mux_sel=0.
- Not defined: ports are absent and no flag logic is synthesised. Other behaviour is identical.

Test Plan:
- Reset, then load 4 words 0x1..0x4 with mux_sel=0 -> word_count=4; m_axis_tvalid rises 2 cycles after the first write; m_axis_tdata=0x1.
- mux_sel=1, loopback_valid=1, tready=1 for 12 cycles after 4-word load -> output sequence 1,2,3,4,1,2,3,4,1,2,3,4; word_count stays 4.
- Fill to 1024 words, then loop-back tready=1 for 2048 cycles -> no stall, word_count=1024 throughout, s_axis_tready=0, order preserved across pointer wrap.
- mux_sel=0, tready=1 on 3 loaded words -> 3 pops then empty; further tready gives m_axis_tvalid=0 and m_axis_tdata=0. With WFIFO_ERR_FLAGS_EN: underflow_err stays 0 (load mode), then repeating in loop-back mode sets it to 1.
- flush pulsed during loop-back with word_count=8 -> next cycle word_count=0 and m_axis_tvalid=0; new PS load plays from the fresh data.
- rst pulsed low mid-loop-back (asynchronous, between edges) -> outputs clear immediately, without waiting for a clock edge; after release, word_count=0 and s_axis_tready returns to 1 one cycle after mux_sel=0.
